// File: rtl/pixel_en_gen.sv
// pixel_en_gen: fractional pixel-clock-enable generator (phase accumulator / NCO).
//
// Emits a registered one-cycle strobe en_o whose average rate is
// inc/2^ACC_WIDTH of clk_i. A small mode table selects the increment, so
// one fabric clock can serve several video modes. A mode change is taken
// through a valid/ready handshake. After the change there is a settle window,
// during which en_o is gated off and locked_o is low.
//
// Ports:
//   clk_i         in   single clock; every register is in this domain
//   reset_i       in   asynchronous, active-high reset
//   mode_i        in   requested mode index
//   mode_valid_i  in   mode request valid
//   mode_ready_o  out  request can be accepted (high in RUN)
//   hold_i        in   freeze accumulator and suppress en_o
//   en_o          out  registered pixel-enable strobe
//   locked_o      out  output rate is stable (high in RUN)
//   mode_o        out  currently active mode
//
// States:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_SETTLE | window after reset/mode switch; acc runs, en_o forced 0
//   ST_RUN    | locked; en_o follows the accumulator carry, requests taken

module pixel_en_gen #(
    parameter int                      ACC_WIDTH     = 16,
    parameter int                      NUM_MODES     = 4,
    parameter int                      MODE_WIDTH    = 2,
    parameter logic [ACC_WIDTH-1:0]    INC_0         = ACC_WIDTH'(2**(ACC_WIDTH-1)),
    parameter logic [ACC_WIDTH-1:0]    INC_1         = ACC_WIDTH'(2**(ACC_WIDTH-2)),
    parameter logic [ACC_WIDTH-1:0]    INC_2         = ACC_WIDTH'(3*(2**(ACC_WIDTH-2))),
    parameter logic [ACC_WIDTH-1:0]    INC_3         = '0,
    parameter int                      SETTLE_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [MODE_WIDTH-1:0] mode_i,
    input  logic                  mode_valid_i,
    output logic                  mode_ready_o,
    input  logic                  hold_i,
    output logic                  en_o,
    output logic                  locked_o,
    output logic [MODE_WIDTH-1:0] mode_o
);

    // Counter must hold SETTLE_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q,   acc_d;
    logic [ACC_WIDTH-1:0]    inc_q,   inc_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [MODE_WIDTH-1:0]   mode_q,  mode_d;
    logic                    en_q,    en_d;

    logic [ACC_WIDTH:0]      sum;
    logic                    carry;
    logic                    accept;
    logic [MODE_WIDTH-1:0]   mode_sel;

    function automatic logic [ACC_WIDTH-1:0] inc_of(input logic [MODE_WIDTH-1:0] m);
        case (int'(m))
            1:       return INC_1;
            2:       return INC_2;
            3:       return INC_3;
            default: return INC_0;
        endcase
    endfunction

    assign sum      = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry    = sum[ACC_WIDTH];
    assign accept   = mode_valid_i & (state_q == ST_RUN);
    // Out-of-table indices fall back to mode 0 rather than an undefined rate.
    assign mode_sel = (int'(mode_i) >= NUM_MODES) ? '0 : mode_i;

    always_comb begin
        state_d = state_q;
        acc_d   = hold_i ? acc_q : sum[ACC_WIDTH-1:0];
        inc_d   = inc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        en_d    = (state_q == ST_RUN) & ~hold_i & carry;

        case (state_q)
            ST_SETTLE: begin
                // Counts regardless of hold_i so the window length is fixed.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // An accepted request overrides hold_i and restarts the phase.
                if (accept) begin
                    mode_d  = mode_sel;
                    inc_d   = inc_of(mode_sel);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                    en_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_SETTLE;
            acc_q   <= '0;
            inc_q   <= INC_0;
            cnt_q   <= '0;
            mode_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
        end
    end

    // Decoded straight from the state flop so these never glitch.
    assign locked_o     = (state_q == ST_RUN);
    assign mode_ready_o = (state_q == ST_RUN);
    assign en_o         = en_q;
    assign mode_o       = mode_q;

endmodule
